mem_bus_target: RTL and testbench

Memory-side responder for the core's single-cycle memory bus. It serves `mem_read`/`mem_write` requests from the CPU with a byte-strobed word RAM and, optionally, a small MMIO block. The MMIO block holds a console transmit FIFO and a 64-bit cycle counter. It sits at top level beside the core and is the only target on that bus.

---
 rtl/mem_bus_target_if.sv | 24 ++
 rtl/mem_bus_target.sv | 174 +++++++++++++++++
 tb/tb_mem_bus_target.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_target_if.sv
// Bus bundle between the core (master) and mem_bus_target (slave),
// including the console byte-sink handshake and the fault pulse.
interface mem_bus_target_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        fault;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb, tx_ready,
    input  mem_rdata, tx_valid, tx_data, fault
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb, tx_ready,
    output mem_rdata, tx_valid, tx_data, fault
  );
endinterface

// File: rtl/mem_bus_target.sv
// Single-cycle memory bus responder: byte-strobed word RAM plus an MMIO window
// (console TX FIFO, 64-bit cycle counter) built only when MEM_BUS_TARGET_MMIO_EN is defined.
module mem_bus_target #(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [63:0] CYC_RESET  = 64'd0
) (
  input logic             clk,
  input logic             rst,
  mem_bus_target_if.slave bus
);
  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [AW-1:0] ram_idx_s;
  logic          ram_hit_s;
  logic          mmio_hit_s;
  logic          unmapped_s;
  logic [31:0]   mmio_rdata_s;
  logic          fault_q;

  assign ram_idx_s  = bus.mem_addr[AW+1:2];
  assign ram_hit_s  = ({1'b0, bus.mem_addr} < RAM_BYTES);
  assign unmapped_s = !ram_hit_s && !mmio_hit_s;

  // RAM byte-lane write; contents survive reset and nothing commits on a reset edge
  always_ff @(posedge clk) begin
    if (!rst && bus.mem_write && ram_hit_s) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.mem_wstrb[n]) begin
          ram_q[ram_idx_s][8*n +: 8] <= bus.mem_wdata[8*n +: 8];
        end
      end
    end
  end

  // Combinational read mux; shows pre-write contents on a simultaneous read/write
  always_comb begin
    bus.mem_rdata = 32'd0;
    if (!bus.mem_read) begin
      bus.mem_rdata = 32'd0;
    end else if (ram_hit_s) begin
      bus.mem_rdata = ram_q[ram_idx_s];
    end else if (mmio_hit_s) begin
      bus.mem_rdata = mmio_rdata_s;
    end else begin
      bus.mem_rdata = 32'd0;
    end
  end

  // One-cycle fault pulse for any access that hits nothing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= (bus.mem_read || bus.mem_write) && unmapped_s;
    end
  end

  assign bus.fault = fault_q;

`ifdef MEM_BUS_TARGET_MMIO_EN
  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(FIFO_DEPTH);

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [63:0]   cycles_q;
  logic [31:0]   cyc_hi_q, cyc_hi_d;
  logic [1:0]    reg_sel_s;
  logic          mmio_wr_s, full_s, empty_s, pop_s, push_req_s, push_s;

  assign mmio_hit_s = (bus.mem_addr[31:4] == MMIO_BASE[31:4]);
  assign reg_sel_s  = bus.mem_addr[3:2];
  assign mmio_wr_s  = bus.mem_write && mmio_hit_s && bus.mem_wstrb[0];
  assign empty_s    = (count_q == (PW+1)'(0));
  assign full_s     = (count_q == CNT_MAX);
  assign pop_s      = !empty_s && bus.tx_ready;
  assign push_req_s = mmio_wr_s && (reg_sel_s == 2'd0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is not an overflow
  assign push_s     = push_req_s && (!full_s || pop_s);

  assign bus.tx_valid = !empty_s;
  assign bus.tx_data  = empty_s ? 8'h00 : fifo_q[rd_ptr_q];

  always_comb begin
    mmio_rdata_s = 32'd0;
    case (reg_sel_s)
      2'd0:    mmio_rdata_s = 32'd0;
      2'd1:    mmio_rdata_s = {29'd0, ovf_q, full_s, empty_s};
      2'd2:    mmio_rdata_s = cycles_q[31:0];
      2'd3:    mmio_rdata_s = cyc_hi_q;
      default: mmio_rdata_s = 32'd0;
    endcase
  end

  // Next state for FIFO pointers/count, sticky overflow and the CYC_HI shadow
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cyc_hi_d = cyc_hi_q;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push_req_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (mmio_wr_s && (reg_sel_s == 2'd1) && bus.mem_wdata[2]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (bus.mem_read && mmio_hit_s && (reg_sel_s == 2'd2)) begin
      cyc_hi_d = cycles_q[63:32];
    end else begin
      cyc_hi_d = cyc_hi_q;
    end
  end

  // MMIO state registers; reset flushes the FIFO at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cyc_hi_q <= 32'd0;
      cycles_q <= CYC_RESET;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cyc_hi_q <= cyc_hi_d;
      cycles_q <= cycles_q + 64'd1;
    end
  end

  // FIFO byte storage
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      fifo_q[wr_ptr_q] <= bus.mem_wdata[7:0];
    end
  end
`else
  logic unused_s;

  assign mmio_hit_s   = 1'b0;
  assign mmio_rdata_s = 32'd0;
  assign bus.tx_valid = 1'b0;
  assign bus.tx_data  = 8'h00;
  assign unused_s     = bus.tx_ready;
`endif
endmodule

// File: tb/tb_mem_bus_target.sv
// Directed bench for mem_bus_target: queue/array reference model checked every cycle,
// plus literal expectations from the test plan.
module tb_mem_bus_target;
  localparam int          RAM_WORDS  = 1024;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] MMIO_BASE  = 32'h1000_0000;
  localparam logic [63:0] CYC_RESET  = 64'h0000_0000_FFFF_FE00;
`ifdef MEM_BUS_TARGET_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_bus_target_if bus_if();

  mem_bus_target #(
    .RAM_WORDS (RAM_WORDS),
    .MMIO_BASE (MMIO_BASE),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CYC_RESET (CYC_RESET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  logic [31:0] m_ram   [RAM_WORDS];
  logic [3:0]  m_known [RAM_WORDS];
  logic [7:0]  m_fifo  [$];
  bit          m_ovf;
  bit          m_fault;
  logic [63:0] m_cyc;
  logic [31:0] m_shadow;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one update per clock edge from the bus values held across it
  task automatic model_edge();
    logic [31:0] a;
    bit          is_ram, is_mmio, pop;
    int          w;
    a = bus_if.mem_addr;
    if (rst) begin
      m_fifo.delete();
      m_ovf    = 1'b0;
      m_fault  = 1'b0;
      m_cyc    = CYC_RESET;
      m_shadow = 32'd0;
      return;
    end
    is_ram  = (a < 32'(RAM_WORDS * 4));
    is_mmio = MMIO_EN && (a[31:4] == MMIO_BASE[31:4]);
    m_fault = (bus_if.mem_read || bus_if.mem_write) && !is_ram && !is_mmio;
    pop = (m_fifo.size() > 0) && bus_if.tx_ready;
    if (pop) void'(m_fifo.pop_front());
    if (bus_if.mem_write && is_ram) begin
      w = int'(a >> 2);
      for (int n = 0; n < 4; n++) begin
        if (bus_if.mem_wstrb[n]) begin
          m_ram[w][8*n +: 8] = bus_if.mem_wdata[8*n +: 8];
          m_known[w][n] = 1'b1;
        end
      end
    end
    if (bus_if.mem_write && is_mmio && bus_if.mem_wstrb[0]) begin
      if (a[3:2] == 2'd0) begin
        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(bus_if.mem_wdata[7:0]);
        else m_ovf = 1'b1;
      end else if (a[3:2] == 2'd1 && bus_if.mem_wdata[2]) begin
        m_ovf = 1'b0;
      end
    end
    if (bus_if.mem_read && is_mmio && a[3:2] == 2'd2) m_shadow = m_cyc[63:32];
    m_cyc = m_cyc + 64'd1;
  endtask

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 4'h0;
    m_ovf = 1'b0; m_fault = 1'b0; m_cyc = CYC_RESET; m_shadow = 32'd0;
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // Compare DUT outputs with the model on every falling edge outside reset
  initial begin
    forever begin
      logic [31:0] a, e;
      bit          known, empty, full;
      @(negedge clk);
      if (cmp_en && !rst) begin
        a     = bus_if.mem_addr;
        known = 1'b1;
        e     = 32'd0;
        empty = (m_fifo.size() == 0);
        full  = (m_fifo.size() == FIFO_DEPTH);
        if (!bus_if.mem_read) begin
          e = 32'd0;
        end else if (a < 32'(RAM_WORDS * 4)) begin
          if (m_known[int'(a >> 2)] == 4'hF) e = m_ram[int'(a >> 2)];
          else known = 1'b0;
        end else if (MMIO_EN && a[31:4] == MMIO_BASE[31:4]) begin
          case (a[3:2])
            2'd1:    e = {29'd0, m_ovf, full, empty};
            2'd2:    e = m_cyc[31:0];
            2'd3:    e = m_shadow;
            default: e = 32'd0;
          endcase
        end
        if (known) check("model_rdata", bus_if.mem_rdata, e);
        check("model_fault", 32'(bus_if.fault), 32'(m_fault));
        check("model_tx_valid", 32'(bus_if.tx_valid), 32'(!empty));
        check("model_tx_data", 32'(bus_if.tx_data), empty ? 32'd0 : 32'(m_fifo[0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.mem_read  = 1'b0;
    bus_if.mem_write = 1'b0;
    bus_if.mem_addr  = 32'd0;
    bus_if.mem_wdata = 32'd0;
    bus_if.mem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_if.mem_write = 1'b1;
    bus_if.mem_addr  = a;
    bus_if.mem_wdata = d;
    bus_if.mem_wstrb = s;
    step();
    idle();
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus_if.mem_read = 1'b1;
    bus_if.mem_addr = a;
    #1;
    check(name, bus_if.mem_rdata, exp);
    step();
    idle();
  endtask

  task automatic drain(output int cnt, output logic [7:0] last);
    cnt  = 0;
    last = 8'h00;
    bus_if.tx_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!bus_if.tx_valid) break;
      last = bus_if.tx_data;
      cnt++;
      step();
    end
  endtask

  initial begin
    int         cnt;
    logic [7:0] last;
    int         guard;
    idle();
    bus_if.tx_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst_rdata", bus_if.mem_rdata, 32'd0);
    check("rst_fault", 32'(bus_if.fault), 32'd0);
    check("rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus_if.tx_data), 32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    wr(32'h10, 32'h0000_00AA, 4'h1);
    rd_chk("ram_strobe", 32'h10, 32'hDEAD_BEAA);

    wr(32'h20, 32'h1111_1111, 4'hF);
    bus_if.mem_read  = 1'b1;
    bus_if.mem_write = 1'b1;
    bus_if.mem_addr  = 32'h20;
    bus_if.mem_wdata = 32'h2222_2222;
    bus_if.mem_wstrb = 4'hF;
    #1;
    check("rw_old_data", bus_if.mem_rdata, 32'h1111_1111);
    step();
    idle();
    #1;
    check("rw_no_fault", 32'(bus_if.fault), 32'd0);
    rd_chk("rw_new_data", 32'h20, 32'h2222_2222);
    wr(32'h20, 32'h3333_3333, 4'h0);
    rd_chk("strobe_zero", 32'h20, 32'h2222_2222);

    wr(32'h0, 32'h0BAD_F00D, 4'hF);
    wr(32'hFFC, 32'hCAFE_F00D, 4'hF);
    rd_chk("ram_last_word", 32'hFFC, 32'hCAFE_F00D);
    wr(32'h1000, 32'hFFFF_FFFF, 4'hF);
    #1;
    check("fault_wr_edge", 32'(bus_if.fault), 32'd1);
    step();
    check("fault_wr_clear", 32'(bus_if.fault), 32'd0);
    rd_chk("ram0_intact", 32'h0, 32'h0BAD_F00D);

    bus_if.mem_read = 1'b1;
    bus_if.mem_addr = 32'h0001_0000;
    #1;
    check("unmapped_rdata", bus_if.mem_rdata, 32'd0);
    step();
    idle();
    #1;
    check("fault_pulse", 32'(bus_if.fault), 32'd1);
    step();
    check("fault_one_cycle", 32'(bus_if.fault), 32'd0);

`ifdef MEM_BUS_TARGET_MMIO_EN
    rd_chk("status_reset", MMIO_BASE + 32'h4, 32'h1);
    for (int i = 0; i < 9; i++) wr(MMIO_BASE, 32'h41 + 32'(i), 4'h1);
    check("fifo_head", 32'(bus_if.tx_data), 32'h41);
    rd_chk("status_ovf_full", MMIO_BASE + 32'h4, 32'h6);
    drain(cnt, last);
    check("drain_count", 32'(cnt), 32'd8);
    check("drain_last", 32'(last), 32'h48);
    rd_chk("status_drained", MMIO_BASE + 32'h4, 32'h5);
    wr(MMIO_BASE + 32'h4, 32'h4, 4'h1);
    rd_chk("status_ovf_clr", MMIO_BASE + 32'h4, 32'h1);

    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(MMIO_BASE, 32'h50 + 32'(i), 4'h1);
    rd_chk("status_full", MMIO_BASE + 32'h4, 32'h2);
    bus_if.tx_ready = 1'b1;
    wr(MMIO_BASE, 32'h58, 4'h1);
    bus_if.tx_ready = 1'b0;
    rd_chk("status_full_pushpop", MMIO_BASE + 32'h4, 32'h2);
    check("head_after_pushpop", 32'(bus_if.tx_data), 32'h51);
    drain(cnt, last);
    check("pushpop_count", 32'(cnt), 32'd8);
    check("pushpop_last", 32'(last), 32'h58);

    bus_if.mem_write = 1'b1;
    bus_if.mem_addr  = MMIO_BASE;
    bus_if.mem_wdata = 32'h60;
    bus_if.mem_wstrb = 4'h1;
    #1;
    check("empty_pushpop_valid", 32'(bus_if.tx_valid), 32'd0);
    step();
    idle();
    #1;
    check("empty_push_rises", 32'(bus_if.tx_valid), 32'd1);
    check("empty_push_data", 32'(bus_if.tx_data), 32'h60);
    step();
    check("empty_push_popped", 32'(bus_if.tx_valid), 32'd0);
`else
    rd_chk("mmio_off_rdata", MMIO_BASE + 32'h4, 32'd0);
    #1;
    check("mmio_off_fault", 32'(bus_if.fault), 32'd1);
    bus_if.tx_ready = 1'b1;
    step();
    check("mmio_off_tx_valid", 32'(bus_if.tx_valid), 32'd0);
`endif

    wr(32'h30, 32'h1234_5678, 4'hF);
`ifdef MEM_BUS_TARGET_MMIO_EN
    bus_if.tx_ready = 1'b0;
    wr(MMIO_BASE, 32'h70, 4'h1);
    wr(MMIO_BASE, 32'h71, 4'h1);
    check("pre_rst_valid", 32'(bus_if.tx_valid), 32'd1);
`endif
    rst = 1'b1;
    bus_if.mem_write = 1'b1;
    bus_if.mem_addr  = 32'h30;
    bus_if.mem_wdata = 32'hFFFF_FFFF;
    bus_if.mem_wstrb = 4'hF;
    #1;
    check("rst_flush_valid", 32'(bus_if.tx_valid), 32'd0);
    check("rst_flush_data", 32'(bus_if.tx_data), 32'd0);
    step();
    step();
    idle();
    rst = 1'b0;
    rd_chk("no_write_in_reset", 32'h30, 32'h1234_5678);

`ifdef MEM_BUS_TARGET_MMIO_EN
    rd_chk("status_after_rst", MMIO_BASE + 32'h4, 32'h1);
    guard = 0;
    while (m_cyc != 64'h0000_0000_FFFF_FFFE && guard < 5000) begin
      step();
      guard++;
    end
    check("cycle_target_reached", 32'(guard < 5000), 32'd1);
    rd_chk("cyc_lo", MMIO_BASE + 32'h8, 32'hFFFF_FFFE);
    step();
    rd_chk("cyc_hi_shadow", MMIO_BASE + 32'hC, 32'h0);
    rd_chk("cyc_lo_carried", MMIO_BASE + 32'h8, 32'h1);
    rd_chk("cyc_hi_carried", MMIO_BASE + 32'hC, 32'h1);
`endif

    step();
    step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
